// File: rtl/prng_pkg.sv
// Shared types and constants for the prng_stream LFSR word generator.
// The AES S-box helpers exist only when PRNG_SBOX_WHITEN_EN is defined.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } prng_state_t;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam logic [7:0]  FIB_TAPS_8  = 8'h94;
  localparam logic [7:0]  GAL_MASK_8  = 8'h70;
  localparam logic [15:0] FIB_TAPS_16 = 16'hB400;
  localparam logic [15:0] GAL_MASK_16 = 16'hB400;
  localparam logic [31:0] FIB_TAPS_32 = 32'h80200003;
  localparam logic [31:0] GAL_MASK_32 = 32'h80200003;

`ifdef PRNG_SBOX_WHITEN_EN
  // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0), then the AES affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
`endif

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step in Fibonacci or Galois form; fb_o is both the
// feedback bit and the generated output bit.
module lfsr_step
  import prng_pkg::*;
#(
  parameter int                 LFSR_W   = 8,
  parameter logic [LFSR_W-1:0]  FIB_TAPS = LFSR_W'(FIB_TAPS_8),
  parameter logic [LFSR_W-1:0]  GAL_MASK = LFSR_W'(GAL_MASK_8)
) (
  input  logic [LFSR_W-1:0] state_i,
  input  logic              mode_i,
  output logic [LFSR_W-1:0] next_o,
  output logic              fb_o
);

  always_comb begin
    if (mode_i == MODE_GAL) begin
      fb_o   = state_i[LFSR_W-1];
      next_o = {state_i[LFSR_W-2:0], fb_o} ^ (fb_o ? GAL_MASK : '0);
    end else begin
      fb_o   = ^(state_i & FIB_TAPS);
      next_o = {state_i[LFSR_W-2:0], fb_o};
    end
  end

endmodule

// File: rtl/prng_stream.sv
// Seeded LFSR word stream with valid/ready output; first word OUT_W+2 cycles after start,
// word and LFSR freeze while out_ready is low. Optional AES S-box whitening: PRNG_SBOX_WHITEN_EN.
module prng_stream
  import prng_pkg::*;
#(
  parameter int                 LFSR_W   = 8,
  parameter int                 OUT_W    = 8,
  parameter logic [LFSR_W-1:0]  FIB_TAPS = LFSR_W'(FIB_TAPS_8),
  parameter logic [LFSR_W-1:0]  GAL_MASK = LFSR_W'(GAL_MASK_8)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic              mode,
  input  logic              cont,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  prng_state_t       state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic              mode_q, mode_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;

  logic [LFSR_W-1:0] step_next;
  logic              step_fb;
  logic [OUT_W-1:0]  word_shift;
  logic [OUT_W-1:0]  word_out;

  lfsr_step #(
    .LFSR_W   (LFSR_W),
    .FIB_TAPS (FIB_TAPS),
    .GAL_MASK (GAL_MASK)
  ) u_step (
    .state_i (lfsr_q),
    .mode_i  (mode_q),
    .next_o  (step_next),
    .fb_o    (step_fb)
  );

  // First generated bit migrates up to the word MSB.
  assign word_shift = (word_q << 1) | OUT_W'(step_fb);

`ifdef PRNG_SBOX_WHITEN_EN
  if ((OUT_W % 8) != 0) begin : g_bad_width
    $error("prng_stream: S-box whitening needs OUT_W to be a multiple of 8");
  end
  for (genvar b = 0; b < OUT_W / 8; b++) begin : g_sbox
    assign word_out[b*8 +: 8] = aes_sbox(word_shift[b*8 +: 8]);
  end
`else
  assign word_out = word_shift;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d  = (seed == '0) ? LFSR_W'(1) : seed;
          mode_d  = mode;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        lfsr_d  = seed_q;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        lfsr_d = step_next;
        word_d = word_shift;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          data_d  = word_out;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = cont ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      seed_q  <= '0;
      mode_q  <= MODE_FIB;
      word_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prng_stream.sv
// Directed bench for prng_stream (LFSR_W=8, OUT_W=8): expected words are queued
// at start and compared when the DUT completes a handshake.
module tb_prng_stream;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic       mode;
  logic       cont;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  prng_stream #(.LFSR_W(8), .OUT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .mode      (mode),
    .cont      (cont),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  function automatic logic [7:0] whiten(input logic [7:0] raw);
`ifdef PRNG_SBOX_WHITEN_EN
    case (raw)
      8'h2D:   return 8'hD8;
      8'hB1:   return 8'hC8;
      8'hFD:   return 8'h54;
      default: return raw;
    endcase
`else
    return raw;
`endif
  endfunction

  // Eight Fibonacci steps (taps 8'h94) from state s; returns the generated word.
  function automatic logic [7:0] fib_word(input logic [7:0] s);
    logic [7:0] st;
    logic [7:0] w;
    logic       fb;
    st = s;
    w  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb = ^(st & 8'h94);
      st = {st[6:0], fb};
      w  = {w[6:0], fb};
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents start for one cycle (cycle 0) and leaves the bench in cycle 1.
  task automatic launch(input logic [7:0] s, input logic m, input logic c, input logic [7:0] raw);
    seed  = s;
    mode  = m;
    cont  = c;
    start = 1'b1;
    exp_q.push_back(whiten(raw));
    tick();
    start = 1'b0;
  endtask

  // Returns the number of cycles advanced until out_valid is seen, or -1.
  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Called in a cycle where out_valid && out_ready: the transfer completes at the next edge.
  task automatic take_word(input string tag);
    logic [7:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(out_data), 32'(e));
    end
  endtask

  int lat;
  int stuck;
  int spurious;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    seed      = 8'h00;
    mode      = 1'b0;
    cont      = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    reset = 1'b0;
    tick();

    // Fibonacci single shot: valid in cycle 10 after start, for one cycle.
    launch(8'h01, 1'b0, 1'b0, 8'h2D);
    chk("fib_busy_load", 32'(busy), 32'd1);
    wait_valid(40, lat);
    chk("fib_latency", 32'(lat + 1), 32'd10);
    take_word("fib");
    tick();
    chk("fib_valid_drop", 32'(out_valid), 32'd0);
    chk("fib_idle_busy",  32'(busy),      32'd0);
    chk("fib_data_hold",  32'(out_data),  32'(whiten(8'h2D)));
    tick();

    // Galois single shot.
    launch(8'h80, 1'b1, 1'b0, 8'hB1);
    wait_valid(40, lat);
    chk("gal_latency", 32'(lat + 1), 32'd10);
    take_word("gal");
    tick();
    chk("gal_idle_busy", 32'(busy), 32'd0);

    // Zero seed behaves like seed 1.
    launch(8'h00, 1'b0, 1'b0, 8'h2D);
    wait_valid(40, lat);
    chk("zero_latency", 32'(lat + 1), 32'd10);
    take_word("zero");
    tick();

    // Backpressure: word must hold for 20 stalled cycles, then transfer once.
    out_ready = 1'b0;
    launch(8'h01, 1'b0, 1'b0, 8'h2D);
    wait_valid(40, lat);
    chk("bp_latency", 32'(lat + 1), 32'd10);
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1 && out_data === whiten(8'h2D)) stuck++;
    end
    chk("bp_hold_cycles", 32'(stuck), 32'd20);
    chk("bp_busy_hold", 32'(busy), 32'd1);
    out_ready = 1'b1;
    take_word("bp");
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_idle_busy",  32'(busy),      32'd0);
    tick();

    // Continuous stream: second word continues from state 8'h2D, 9 cycles later.
    launch(8'h01, 1'b0, 1'b1, 8'h2D);
    exp_q.push_back(whiten(fib_word(8'h2D)));
    wait_valid(40, lat);
    chk("cont_latency", 32'(lat + 1), 32'd10);
    take_word("cont_w1");
    wait_valid(40, lat);
    chk("cont_gap", 32'(lat), 32'd9);
    take_word("cont_w2");
    repeat (3) tick();
    chk("cont_shift_busy",  32'(busy),      32'd1);
    chk("cont_shift_valid", 32'(out_valid), 32'd0);

    // Reset mid-SHIFT abandons the word.
    reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",  32'(busy),      32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    reset = 1'b0;
    cont  = 1'b0;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    chk("midrst_no_word", 32'(spurious), 32'd0);

    // Start while busy is ignored: a second start during SHIFT adds no word.
    launch(8'h80, 1'b1, 1'b0, 8'hB1);
    repeat (3) tick();
    seed  = 8'h01;
    mode  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(40, lat);
    chk("busy_start_latency", 32'(lat + 5), 32'd10);
    take_word("busy_start");
    tick();
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0) spurious++;
    end
    chk("busy_start_ignored", 32'(spurious), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prng_stream.md
Name: prng_stream

Overview:
- Parametrised successor to the 8-bit single-shot PRNG.
- LFSR width, output word width and tap polynomials are configurable, and Fibonacci/Galois mode is selected at run time.
- Adds a valid/ready output handshake with backpressure, plus continuous word generation from a single seed.
- Sits between the chip I/O wrapper and downstream consumers of random words.

Parameters:
- LFSR_W, 8, LFSR state width (>=4)
- OUT_W, 8, output word width (bits shifted per word, 1..32)
- FIB_TAPS, 8'h94, Fibonacci tap mask (LFSR_W bits); feedback = XOR-reduce(state & FIB_TAPS)
- GAL_MASK, 8'h70, Galois toggle mask (LFSR_W bits), XORed into next state when feedback=1

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- seed  in  LFSR_W  seed, captured with start
- mode  in  1  0=Fibonacci, 1=Galois; captured with start
- cont  in  1  1=continuous stream; sampled at each completed handshake
- out_ready  in  1  consumer ready
- out_data  out  OUT_W  random word
- out_valid  out  1  out_data valid
- busy  out  1  high in any state except IDLE

Behaviour:
- Synchronous reset on posedge clock:
  - FSM goes to IDLE.
  - LFSR state, shift register, bit counter and out_data are cleared to 0.
  - out_valid=0, busy=0.
  - Reset mid-operation abandons the current word, and no partial word is emitted.
- FSM states: IDLE, LOAD, SHIFT, HOLD.
- IDLE:
  - start=1 captures seed and mode; next state is LOAD.
  - A seed of all zeros is replaced by 1 (zero-lock guard).
- LOAD (1 cycle): LFSR <= captured seed, bit counter <= 0; next state is SHIFT.
- SHIFT, one LFSR step per cycle:
  - Fibonacci: fb = ^(s & FIB_TAPS); s <= {s[LFSR_W-2:0], fb}.
  - Galois: fb = s[LFSR_W-1]; s <= {s[LFSR_W-2:0], fb} ^ (fb ? GAL_MASK : 0).
  - In both modes the output bit is fb, shifted into the word LSB-first-in (word <= {word[OUT_W-2:0], fb}), so the first bit generated ends up as the word MSB.
  - Counter increments each cycle; after OUT_W steps (counter wraps at OUT_W-1), the word is loaded into out_data and the next state is HOLD.
- HOLD:
  - out_valid=1; out_data and LFSR state are frozen while out_ready=0.
  - On out_valid && out_ready: out_valid drops the next cycle.
    - If cont=1, next state is SHIFT, continuing from the current LFSR state with no reseed.
    - Otherwise next state is IDLE.
- Latency: start accepted at cycle 0 → out_valid high at cycle OUT_W+2. In continuous mode with out_ready held at 1, consecutive words are OUT_W+1 cycles apart.
- start while busy is ignored; no queueing.
- Mode cannot change mid-stream; a new mode requires returning to IDLE.
- out_data holds its last value in IDLE.

Optional Feature:
- PRNG_SBOX_WHITEN_EN defined:
  - out_data is passed through the standard AES S-box per byte lane before it is registered.
  - Requires OUT_W to be a multiple of 8; elaboration error otherwise.
  - No added latency.
- Undefined: out_data is the raw LFSR word, and no S-box logic is instantiated.

Decomposition:
- Package prng_pkg holds:
  - the FSM state enum prng_state_t (2 bits);
  - the mode constants MODE_FIB=0 and MODE_GAL=1;
  - default tap constants for widths 8, 16 and 32: 8'h94/8'h70, 16'hB400/16'hB400, 32'h80200003/32'h80200003.
- One sub-module, lfsr_step (combinational, parametrised by LFSR_W, FIB_TAPS and GAL_MASK), takes state and mode and returns next-state and fb. The FSM and registers stay in prng_stream.

Test Plan (LFSR_W=8, OUT_W=8, defaults, feature off unless noted):
- Fibonacci single-shot: seed=8'h01, mode=0, cont=0, start 1 cycle, out_ready=1 → out_data=8'h2D, out_valid high for exactly 1 cycle at cycle 10 after start; then IDLE, busy=0.
- Galois single-shot: seed=8'h80, mode=1 → out_data=8'hB1.
- Zero-seed guard: seed=8'h00, mode=0 → out_data=8'h2D, identical to seed 8'h01.
- Backpressure: Fibonacci seed 8'h01, out_ready=0 for 20 cycles → out_valid stays 1, out_data stays 8'h2D; raising out_ready completes one transfer.
- Continuous plus reset: cont=1, out_ready=1 → words arrive 9 cycles apart, and the second word equals the first 8 steps continued from state 8'h2D. Asserting reset during SHIFT gives out_valid=0, busy=0, out_data=0 on the next cycle, and no word is emitted.
- With PRNG_SBOX_WHITEN_EN: Fibonacci seed 8'h01 → out_data=8'hD8 (S-box of 8'h2D), same latency.
